// File: rtl/ddr_addr_pkg.sv
// rtl/ddr_addr_pkg.sv - shared constants, FSM encoding and slot address helper for DDR frame address controllers
package ddr_addr_pkg;

    localparam logic [31:0] DEF_START_ADDR = 32'h0080_0000;
    localparam logic [31:0] DEF_BLOCK_SIZE = 32'h0008_0000;
    localparam logic [31:0] DEF_WR_NUM     = 32'd5400;
    localparam logic [31:0] DEF_RD_NUM     = 32'd5400;
    localparam int          FRAME_CNT_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } addr_state_t;

    // Word address of a slot converted to a byte address; callers truncate.
    function automatic logic [31:0] slot_byte_addr(input logic [31:0]            start_addr,
                                                   input logic [31:0]            block_size,
                                                   input logic [FRAME_CNT_W-1:0] slot);
        logic [31:0] word_addr;
        word_addr = start_addr + block_size * {{(32-FRAME_CNT_W){1'b0}}, slot};
        return word_addr << 2;
    endfunction

endpackage

// File: rtl/sync_rise3.sv
// rtl/sync_rise3.sv - three-flop synchronizer with rising-edge detect
module sync_rise3 (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [2:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= 3'b000;
        end else begin
            sr <= {sr[1:0], din};
        end
    end

    // sr[0] is the metastability stage; the edge is taken from the settled pair.
    assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/rd_frame_addr_ctr.sv
// rtl/rd_frame_addr_ctr.sv - read-side frame slot selection and DDR read burst request
module rd_frame_addr_ctr
    import ddr_addr_pkg::*;
#(
    parameter logic [31:0] START_ADDR   = DEF_START_ADDR,
    parameter logic [31:0] BLOCK_SIZE   = DEF_BLOCK_SIZE,
    parameter logic [31:0] RD_NUM       = DEF_RD_NUM,
    parameter int          ADDR_WIDTH   = 30,
    parameter int          RD_NUM_WIDTH = 28,
    parameter int          REQ_CYCLES   = 5,
    parameter logic [23:0] TIMEOUT_CYC  = 24'd2_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_vs,
    input  logic                    rd_ddr_done,
    input  logic [FRAME_CNT_W-1:0]  wr_fram_cnt,
    output logic                    rd_addr_valid,
    output logic [ADDR_WIDTH-1:0]   rd_ddr_addr,
    output logic [RD_NUM_WIDTH-1:0] rd_ddr_num,
    output logic [FRAME_CNT_W-1:0]  rd_fram_cnt,
    output logic                    rd_vs_out,
    output logic                    frame_repeat,
    output logic                    rd_timeout
);

    localparam logic [ADDR_WIDTH-1:0] RST_ADDR = ADDR_WIDTH'(slot_byte_addr(START_ADDR, BLOCK_SIZE, 3'd0));
    localparam logic [7:0]            REQ_LAST = 8'(REQ_CYCLES);

    logic                   vs_rise;
    logic                   done_rise;
    logic [FRAME_CNT_W-1:0] wr_s1, wr_s2, wr_s3;
    logic [FRAME_CNT_W-1:0] wr_cnt_s;
    logic                   started;
    logic [FRAME_CNT_W-1:0] cand;
    logic [FRAME_CNT_W-1:0] prev_slot;
    logic [7:0]             req_cnt;
    logic [23:0]            tmo_cnt;
    addr_state_t            state;

    sync_rise3 u_vs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (rd_vs),
        .rise (vs_rise)
    );

    sync_rise3 u_done_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (rd_ddr_done),
        .rise (done_rise)
    );

    // Writer counter: only accept a value seen on two consecutive synced samples,
    // so a multi-bit transition caught mid-change never selects a bogus slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_s1    <= '0;
            wr_s2    <= '0;
            wr_s3    <= '0;
            wr_cnt_s <= '0;
            started  <= 1'b0;
        end else begin
            wr_s1 <= wr_fram_cnt;
            wr_s2 <= wr_s1;
            wr_s3 <= wr_s2;
            if (wr_s2 == wr_s3) begin
                wr_cnt_s <= wr_s2;
                if (wr_s2 != wr_cnt_s) begin
                    started <= 1'b1;
                end
            end
        end
    end

    // Newest completed slot is the one just behind the slot being written.
    assign cand       = started ? (wr_cnt_s - 3'd1) : 3'd0;
    assign rd_ddr_num = RD_NUM[RD_NUM_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rd_addr_valid <= 1'b0;
            rd_vs_out     <= 1'b0;
            rd_timeout    <= 1'b0;
            rd_fram_cnt   <= '0;
            prev_slot     <= 3'd7;
            frame_repeat  <= 1'b1;
            rd_ddr_addr   <= RST_ADDR;
            req_cnt       <= '0;
            tmo_cnt       <= '0;
        end else begin
            rd_vs_out  <= 1'b0;
            rd_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (vs_rise) begin
                        state        <= REQ;
                        rd_fram_cnt  <= cand;
                        rd_ddr_addr  <= ADDR_WIDTH'(slot_byte_addr(START_ADDR, BLOCK_SIZE, cand));
                        rd_vs_out    <= 1'b1;
                        frame_repeat <= started ? (cand == prev_slot) : 1'b1;
                        req_cnt      <= '0;
                    end
                end
                REQ: begin
                    if (req_cnt == REQ_LAST) begin
                        rd_addr_valid <= 1'b0;
                        state         <= WAIT;
                        tmo_cnt       <= '0;
                    end else begin
                        rd_addr_valid <= 1'b1;
                        req_cnt       <= req_cnt + 8'd1;
                    end
                end
                WAIT: begin
                    // A done arriving on the timeout cycle still counts as a completed read.
                    if (done_rise) begin
                        prev_slot <= rd_fram_cnt;
                        state     <= IDLE;
                    end else if (tmo_cnt == TIMEOUT_CYC - 24'd1) begin
                        rd_timeout <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 24'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rd_frame_addr_ctr.sv
// tb/tb_rd_frame_addr_ctr.sv - randomized self-checking bench for rd_frame_addr_ctr
module tb_rd_frame_addr_ctr;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_vs;
    logic        rd_ddr_done;
    logic [2:0]  wr_fram_cnt;
    logic        rd_addr_valid;
    logic [29:0] rd_ddr_addr;
    logic [27:0] rd_ddr_num;
    logic [2:0]  rd_fram_cnt;
    logic        rd_vs_out;
    logic        frame_repeat;
    logic        rd_timeout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [2:0] m_wr;
    bit         m_started;
    logic [2:0] m_prev;
    logic [2:0] m_slot;

    always #5 clk = ~clk;

    rd_frame_addr_ctr #(
        .TIMEOUT_CYC (24'd100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_vs         (rd_vs),
        .rd_ddr_done   (rd_ddr_done),
        .wr_fram_cnt   (wr_fram_cnt),
        .rd_addr_valid (rd_addr_valid),
        .rd_ddr_addr   (rd_ddr_addr),
        .rd_ddr_num    (rd_ddr_num),
        .rd_fram_cnt   (rd_fram_cnt),
        .rd_vs_out     (rd_vs_out),
        .frame_repeat  (frame_repeat),
        .rd_timeout    (rd_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_addr(input logic [2:0] slot);
        logic [31:0] a;
        a = (32'h0080_0000 + 32'(slot) * 32'h0008_0000) * 4;
        return a & 32'h3FFF_FFFF;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, rd_addr_valid, 0);
        check({tag, "_vs_out"}, rd_vs_out, 0);
        check({tag, "_timeout"}, rd_timeout, 0);
        check({tag, "_fram_cnt"}, rd_fram_cnt, 0);
        check({tag, "_repeat"}, frame_repeat, 1);
        check({tag, "_addr"}, rd_ddr_addr, 32'h0200_0000);
    endtask

    task automatic set_wr(input logic [2:0] v);
        @(negedge clk);
        wr_fram_cnt = v;
        repeat (6) @(negedge clk);
        m_wr = v;
        if (v != 3'd0) m_started = 1'b1;
    endtask

    task automatic start_req(input bit toggle_vs);
        int lat;
        int vcnt;
        int extra;
        logic rep;
        m_slot = m_started ? (m_wr - 3'd1) : 3'd0;
        rep    = m_started ? (m_slot == m_prev) : 1'b1;
        rd_vs  = 1'b1;
        lat    = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (rd_vs_out) lat = i;
        end
        check("vs_latency", lat, 3);
        check("rd_fram_cnt", rd_fram_cnt, m_slot);
        check("rd_ddr_addr", rd_ddr_addr, exp_addr(m_slot));
        check("frame_repeat", frame_repeat, rep);
        check("rd_ddr_num", rd_ddr_num, 5400);
        check("valid_not_yet", rd_addr_valid, 0);
        @(negedge clk);
        rd_vs = 1'b0;
        check("vs_out_width", rd_vs_out, 0);
        vcnt  = 0;
        extra = 0;
        for (int i = 0; i < 12 && rd_addr_valid; i++) begin
            vcnt++;
            if (toggle_vs) rd_vs = ~rd_vs;
            @(negedge clk);
            if (rd_vs_out) extra++;
        end
        rd_vs = 1'b0;
        check("valid_len", vcnt, 5);
        check("extra_vs_out", extra, 0);
        check("addr_hold", rd_ddr_addr, exp_addr(m_slot));
        check("slot_hold", rd_fram_cnt, m_slot);
    endtask

    task automatic finish_done(input int d);
        int tmo;
        int extra;
        tmo   = 0;
        extra = 0;
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            if (rd_timeout) tmo++;
            if (rd_vs_out) extra++;
        end
        rd_ddr_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rd_timeout) tmo++;
        end
        rd_ddr_done = 1'b0;
        check("no_timeout", tmo, 0);
        check("wait_vs_out", extra, 0);
        check("wait_addr_hold", rd_ddr_addr, exp_addr(m_slot));
        m_prev = m_slot;
        repeat (3) @(negedge clk);
    endtask

    task automatic finish_timeout();
        int n;
        n = 0;
        for (int i = 1; i <= 150 && n == 0; i++) begin
            @(negedge clk);
            if (rd_timeout) n = i;
        end
        check("timeout_at", n, 100);
        @(negedge clk);
        check("timeout_width", rd_timeout, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        rd_vs       = 1'b0;
        rd_ddr_done = 1'b0;
        wr_fram_cnt = 3'd0;
        m_wr        = 3'd0;
        m_started   = 1'b0;
        m_prev      = 3'd7;
        m_slot      = 3'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_release");

        // Writer has completed slot 0; first read is a fresh slot.
        set_wr(3'd1);
        start_req(1'b0);
        finish_done(8);

        set_wr(3'd3);
        start_req(1'b0);
        finish_done(5);

        // Same writer position again: repeat flagged; vsync chatter ignored.
        start_req(1'b1);
        finish_done(20);

        // Writer wrapped to slot 0, reader takes slot 7; withhold done.
        set_wr(3'd0);
        start_req(1'b0);
        finish_timeout();

        // Timed-out read left prev slot at 2; done lands on the timeout cycle.
        start_req(1'b0);
        finish_done(97);

        start_req(1'b0);
        finish_done(10);

        for (int it = 0; it < 16; it++) begin
            set_wr(3'($urandom_range(0, 7)));
            start_req(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) finish_timeout();
            else finish_done(int'($urandom_range(4, 90)));
        end

        // Reset in the middle of a WAIT, then a stray done.
        set_wr(3'd0);
        start_req(1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid_wait");
        rst         = 1'b0;
        m_prev      = 3'd7;
        m_started   = 1'b0;
        rd_ddr_done = 1'b1;
        repeat (4) @(negedge clk);
        check("stray_done_timeout", rd_timeout, 0);
        check("stray_done_valid", rd_addr_valid, 0);
        rd_ddr_done = 1'b0;
        repeat (6) @(negedge clk);
        start_req(1'b0);
        finish_done(6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1);
    end

endmodule
